// File: rtl/dif_radix2_64p_out_framer.sv
// Output framer for the 64-point DIF radix-2 FFT: bin tagging, optional |X|^2, FWFT FIFO with drop counting.
// Optional magnitude path enabled by defining FFT_OUT_MAG_EN.
module dif_radix2_64p_out_framer #(
    parameter int DATA_WIDTH = 17,
    parameter int FIFO_DEPTH = 16,
    parameter int FFT_NUM    = 6
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [DATA_WIDTH-1:0]   din_re,
    input  logic signed [DATA_WIDTH-1:0]   din_im,
    input  logic                           din_valid,
    output logic                           dout_valid,
    input  logic                           dout_ready,
    output logic signed [DATA_WIDTH-1:0]   dout_re,
    output logic signed [DATA_WIDTH-1:0]   dout_im,
    output logic [2*DATA_WIDTH-1:0]        dout_mag,
    output logic [FFT_NUM-1:0]             dout_bin,
    output logic                           dout_sop,
    output logic                           dout_eop,
    output logic                           ovf,
    output logic [7:0]                     drop_cnt,
    input  logic                           ovf_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int MW = 2 * DATA_WIDTH;
    localparam logic [FFT_NUM-1:0] BIN_MAX = '1;

    logic [FFT_NUM-1:0]            bin_q, bin_d;
    logic                          s1_valid_q, s1_sop_q, s1_eop_q;
    logic signed [DATA_WIDTH-1:0]  s1_re_q, s1_im_q;
    logic [FFT_NUM-1:0]            s1_bin_q;
    logic                          s2_valid_q, s2_sop_q, s2_eop_q;
    logic signed [DATA_WIDTH-1:0]  s2_re_q, s2_im_q;
    logic [FFT_NUM-1:0]            s2_bin_q;

    logic [AW:0]                   wr_ptr_q, rd_ptr_q;
    logic [AW-1:0]                 wr_idx, rd_idx;
    logic                          full, empty, rd_en, wr_en, drop;
    logic                          ovf_q, ovf_d;
    logic [7:0]                    drop_cnt_q, drop_cnt_d;

    logic [DATA_WIDTH-1:0]         mem_re  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]         mem_im  [FIFO_DEPTH];
    logic [FFT_NUM-1:0]            mem_bin [FIFO_DEPTH];
    logic                          mem_sop [FIFO_DEPTH];
    logic                          mem_eop [FIFO_DEPTH];

    assign wr_idx = wr_ptr_q[AW-1:0];
    assign rd_idx = rd_ptr_q[AW-1:0];
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign rd_en  = !empty && dout_ready;
    // A full FIFO still accepts the write when the head leaves on the same edge.
    assign wr_en  = s2_valid_q && (!full || rd_en);
    assign drop   = s2_valid_q && full && !rd_en;

    always_comb begin
        bin_d      = bin_q;
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;
        if (din_valid) bin_d = bin_q + 1'b1;
        if (ovf_clr) begin
            ovf_d      = 1'b0;
            drop_cnt_d = '0;
        end
        if (drop) begin
            ovf_d = 1'b1;
            if (ovf_clr)                  drop_cnt_d = 8'd1;
            else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q      <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            bin_q      <= bin_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_re_q    <= '0;
            s1_im_q    <= '0;
            s1_bin_q   <= '0;
            s1_sop_q   <= 1'b0;
            s1_eop_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_re_q    <= '0;
            s2_im_q    <= '0;
            s2_bin_q   <= '0;
            s2_sop_q   <= 1'b0;
            s2_eop_q   <= 1'b0;
        end else begin
            s1_valid_q <= din_valid;
            if (din_valid) begin
                s1_re_q  <= din_re;
                s1_im_q  <= din_im;
                s1_bin_q <= bin_q;
                s1_sop_q <= (bin_q == '0);
                s1_eop_q <= (bin_q == BIN_MAX);
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_re_q  <= s1_re_q;
                s2_im_q  <= s1_im_q;
                s2_bin_q <= s1_bin_q;
                s2_sop_q <= s1_sop_q;
                s2_eop_q <= s1_eop_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_re[wr_idx]  <= s2_re_q;
            mem_im[wr_idx]  <= s2_im_q;
            mem_bin[wr_idx] <= s2_bin_q;
            mem_sop[wr_idx] <= s2_sop_q;
            mem_eop[wr_idx] <= s2_eop_q;
        end
    end

`ifdef FFT_OUT_MAG_EN
    // Both squares are non-negative and their sum is at most 2^(MW-1), so no saturation.
    logic signed [MW-1:0] sq_re, sq_im;
    logic [MW-1:0]        s2_mag_q;
    logic [MW-1:0]        mem_mag [FIFO_DEPTH];

    assign sq_re = s1_re_q * s1_re_q;
    assign sq_im = s1_im_q * s1_im_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             s2_mag_q <= '0;
        else if (s1_valid_q) s2_mag_q <= $unsigned(sq_re) + $unsigned(sq_im);
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_mag[wr_idx] <= s2_mag_q;
    end

    assign dout_mag = empty ? '0 : mem_mag[rd_idx];
`else
    assign dout_mag = '0;
`endif

    assign dout_valid = !empty;
    assign dout_re    = empty ? '0 : $signed(mem_re[rd_idx]);
    assign dout_im    = empty ? '0 : $signed(mem_im[rd_idx]);
    assign dout_bin   = empty ? '0 : mem_bin[rd_idx];
    assign dout_sop   = !empty && mem_sop[rd_idx];
    assign dout_eop   = !empty && mem_eop[rd_idx];
    assign ovf        = ovf_q;
    assign drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_dif_radix2_64p_out_framer.sv
// Directed bench for dif_radix2_64p_out_framer: tagging, latency, FIFO full/drop, ovf_clr, reset.
module tb_dif_radix2_64p_out_framer;
    logic               clk = 1'b0;
    logic               rst;
    logic signed [16:0] din_re, din_im;
    logic               din_valid;
    logic               dout_valid, dout_ready;
    logic signed [16:0] dout_re, dout_im;
    logic [33:0]        dout_mag;
    logic [5:0]         dout_bin;
    logic               dout_sop, dout_eop, ovf, ovf_clr;
    logic [7:0]         drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

`ifdef FFT_OUT_MAG_EN
    localparam bit MAG_EN = 1'b1;
`else
    localparam bit MAG_EN = 1'b0;
`endif

    dif_radix2_64p_out_framer dut (
        .clk(clk), .rst(rst),
        .din_re(din_re), .din_im(din_im), .din_valid(din_valid),
        .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_re(dout_re), .dout_im(dout_im), .dout_mag(dout_mag),
        .dout_bin(dout_bin), .dout_sop(dout_sop), .dout_eop(dout_eop),
        .ovf(ovf), .drop_cnt(drop_cnt), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1; din_valid = 1'b0; dout_ready = 1'b0; ovf_clr = 1'b0;
        din_re = '0; din_im = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; din_valid = 1'b0; dout_ready = 1'b0; ovf_clr = 1'b0;
        din_re = '0; din_im = '0;
        #2;
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b exp 0", dout_valid); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %0b exp 0", ovf); end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL reset_drop_cnt got %0d exp 0", drop_cnt); end
        n_cmp++; if (dout_re !== 17'sd0 || dout_bin !== 6'd0 || dout_mag !== 34'd0) begin
            n_err++; $display("FAIL reset_data got re=%0d bin=%0d mag=%0d exp 0", dout_re, dout_bin, dout_mag); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_release_valid got %0b exp 0", dout_valid); end
    endtask

    task automatic test_stream();
        logic [33:0] em;
        int k;
        do_reset();
        dout_ready = 1'b1;
        for (int c = 0; c < 68; c++) begin
            @(posedge clk); #1;
            din_valid = (c < 64);
            din_re = 17'(c); din_im = 17'(-c);
            @(negedge clk);
            k = c - 3;
            if (k >= 0 && k < 64) begin
                em = MAG_EN ? 34'(2 * k * k) : 34'd0;
                n_cmp++; if (dout_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid k=%0d got %0b exp 1", k, dout_valid); end
                n_cmp++; if (dout_bin !== 6'(k)) begin n_err++; $display("FAIL stream_bin got %0d exp %0d", dout_bin, k); end
                n_cmp++; if (dout_re !== 17'(k) || dout_im !== 17'(-k)) begin
                    n_err++; $display("FAIL stream_data k=%0d got re=%0d im=%0d exp re=%0d im=%0d", k, dout_re, dout_im, k, -k); end
                n_cmp++; if (dout_sop !== (k == 0) || dout_eop !== (k == 63)) begin
                    n_err++; $display("FAIL stream_sop_eop k=%0d got %0b%0b exp %0b%0b", k, dout_sop, dout_eop, k == 0, k == 63); end
                n_cmp++; if (dout_mag !== em) begin n_err++; $display("FAIL stream_mag k=%0d got %0d exp %0d", k, dout_mag, em); end
            end else begin
                n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL stream_idle_valid c=%0d got %0b exp 0", c, dout_valid); end
            end
        end
    endtask

    task automatic test_extremes();
        do_reset();
        dout_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            din_valid = (c < 2);
            din_re = (c == 0) ? -17'sd65536 : 17'sd65535;
            din_im = (c == 0) ? -17'sd65536 : 17'sd0;
            @(negedge clk);
            if (c == 3) begin
                n_cmp++; if (dout_valid !== 1'b1 || dout_re !== -17'sd65536) begin
                    n_err++; $display("FAIL ext_neg_data got v=%0b re=%0d exp v=1 re=-65536", dout_valid, dout_re); end
                n_cmp++; if (dout_mag !== (MAG_EN ? 34'h2_0000_0000 : 34'd0)) begin
                    n_err++; $display("FAIL ext_neg_mag got %0d exp %0d", dout_mag, MAG_EN ? 34'h2_0000_0000 : 34'd0); end
            end
            if (c == 4) begin
                n_cmp++; if (dout_valid !== 1'b1 || dout_bin !== 6'd1 || dout_re !== 17'sd65535) begin
                    n_err++; $display("FAIL ext_pos_data got v=%0b bin=%0d re=%0d exp v=1 bin=1 re=65535", dout_valid, dout_bin, dout_re); end
                n_cmp++; if (dout_mag !== (MAG_EN ? 34'd4294836225 : 34'd0)) begin
                    n_err++; $display("FAIL ext_pos_mag got %0d exp %0d", dout_mag, MAG_EN ? 34'd4294836225 : 34'd0); end
            end
            if (c == 5) begin
                n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL ext_empty got %0b exp 0", dout_valid); end
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #1;
            din_valid = (c < 20);
            din_re = 17'(100 + c); din_im = 17'(c);
            @(negedge clk);
            if (c == 18) begin
                n_cmp++; if (ovf !== 1'b0 || drop_cnt !== 8'd0) begin
                    n_err++; $display("FAIL ovf_before got ovf=%0b cnt=%0d exp 0/0", ovf, drop_cnt); end
            end
            if (c == 19) begin
                n_cmp++; if (ovf !== 1'b1 || drop_cnt !== 8'd1) begin
                    n_err++; $display("FAIL ovf_first_drop got ovf=%0b cnt=%0d exp 1/1", ovf, drop_cnt); end
            end
        end
        n_cmp++; if (drop_cnt !== 8'd4 || ovf !== 1'b1) begin
            n_err++; $display("FAIL ovf_total got ovf=%0b cnt=%0d exp 1/4", ovf, drop_cnt); end
        n_cmp++; if (dout_valid !== 1'b1 || dout_bin !== 6'd0 || dout_re !== 17'sd100) begin
            n_err++; $display("FAIL ovf_head_hold got v=%0b bin=%0d re=%0d exp 1/0/100", dout_valid, dout_bin, dout_re); end
        @(posedge clk); #1 dout_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n_cmp++; if (dout_valid !== 1'b1 || dout_bin !== 6'(i) || dout_re !== 17'(100 + i)) begin
                n_err++; $display("FAIL ovf_drain got v=%0b bin=%0d re=%0d exp v=1 bin=%0d re=%0d", dout_valid, dout_bin, dout_re, i, 100 + i); end
        end
        @(negedge clk);
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drained got %0b exp 0", dout_valid); end
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            din_valid = (c < 44);
            din_re = 17'(c); din_im = '0;
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            din_valid = (c == 0);
            din_re = 17'sd55; din_im = 17'sd3;
            @(negedge clk);
            if (c == 3) begin
                n_cmp++; if (dout_valid !== 1'b1 || dout_bin !== 6'd0 || dout_sop !== 1'b1 || dout_re !== 17'sd55) begin
                    n_err++; $display("FAIL ovf_next_frame got v=%0b bin=%0d sop=%0b re=%0d exp 1/0/1/55", dout_valid, dout_bin, dout_sop, dout_re); end
                n_cmp++; if (drop_cnt !== 8'd4) begin n_err++; $display("FAIL ovf_cnt_kept got %0d exp 4", drop_cnt); end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c < 39; c++) begin
            @(posedge clk); #1;
            din_valid = (c < 36);
            din_re = 17'(c); din_im = 17'(-c);
            dout_ready = (c >= 18 && c < 38);
            @(negedge clk);
            if (c >= 19) begin
                n_cmp++; if (dout_valid !== 1'b1 || dout_bin !== 6'(c - 18)) begin
                    n_err++; $display("FAIL b2b_head c=%0d got v=%0b bin=%0d exp v=1 bin=%0d", c, dout_valid, dout_bin, c - 18); end
                n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL b2b_ovf c=%0d got %0b exp 0", c, ovf); end
            end
        end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL b2b_drop_cnt got %0d exp 0", drop_cnt); end
        @(posedge clk); #1 dout_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n_cmp++; if (dout_valid !== 1'b1 || dout_bin !== 6'(20 + i)) begin
                n_err++; $display("FAIL b2b_occupancy got v=%0b bin=%0d exp v=1 bin=%0d", dout_valid, dout_bin, 20 + i); end
        end
        @(negedge clk);
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty got %0b exp 0", dout_valid); end
    endtask

    task automatic test_ovf_clr();
        do_reset();
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #1;
            din_valid = (c < 19);
            din_re = 17'(c); din_im = '0;
            ovf_clr = (c == 20) || (c == 22);
            @(negedge clk);
            if (c == 20) begin
                n_cmp++; if (ovf !== 1'b1 || drop_cnt !== 8'd2) begin
                    n_err++; $display("FAIL clr_pre got ovf=%0b cnt=%0d exp 1/2", ovf, drop_cnt); end
            end
            if (c == 21) begin
                n_cmp++; if (ovf !== 1'b1 || drop_cnt !== 8'd1) begin
                    n_err++; $display("FAIL clr_with_drop got ovf=%0b cnt=%0d exp 1/1", ovf, drop_cnt); end
            end
            if (c == 23) begin
                n_cmp++; if (ovf !== 1'b0 || drop_cnt !== 8'd0) begin
                    n_err++; $display("FAIL clr_alone got ovf=%0b cnt=%0d exp 0/0", ovf, drop_cnt); end
            end
        end
        for (int c = 0; c < 306; c++) begin
            @(posedge clk); #1;
            din_valid = (c < 300);
            ovf_clr = 1'b0;
            @(negedge clk);
            if (c == 256 || c == 257 || c == 305) begin
                n_cmp++; if (drop_cnt !== ((c == 256) ? 8'd254 : 8'd255)) begin
                    n_err++; $display("FAIL sat_cnt c=%0d got %0d exp %0d", c, drop_cnt, (c == 256) ? 254 : 255); end
            end
        end
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL sat_ovf got %0b exp 1", ovf); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int c = 0; c < 31; c++) begin
            @(posedge clk); #1;
            din_valid = 1'b1;
            din_re = 17'(c); din_im = 17'(c);
        end
        @(posedge clk); #1;
        din_valid = 1'b0;
        n_cmp++; if (dout_valid !== 1'b1 || ovf !== 1'b1) begin
            n_err++; $display("FAIL midrst_pre got v=%0b ovf=%0b exp 1/1", dout_valid, ovf); end
        rst = 1'b1;
        #1;
        n_cmp++; if (dout_valid !== 1'b0 || ovf !== 1'b0 || drop_cnt !== 8'd0) begin
            n_err++; $display("FAIL midrst_async got v=%0b ovf=%0b cnt=%0d exp 0/0/0", dout_valid, ovf, drop_cnt); end
        n_cmp++; if (dout_bin !== 6'd0 || dout_re !== 17'sd0) begin
            n_err++; $display("FAIL midrst_data got bin=%0d re=%0d exp 0/0", dout_bin, dout_re); end
        #2 rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            din_valid = (c == 0);
            din_re = 17'sd7; din_im = -17'sd7;
            @(negedge clk);
            if (c == 1 || c == 2) begin
                n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL midrst_flushed c=%0d got %0b exp 0", c, dout_valid); end
            end
            if (c == 3) begin
                n_cmp++; if (dout_valid !== 1'b1 || dout_bin !== 6'd0 || dout_sop !== 1'b1 || dout_re !== 17'sd7) begin
                    n_err++; $display("FAIL midrst_first got v=%0b bin=%0d sop=%0b re=%0d exp 1/0/1/7", dout_valid, dout_bin, dout_sop, dout_re); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_extremes();
        test_overflow();
        test_back_to_back();
        test_ovf_clr();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dif_radix2_64p_out_framer.md
# dif_radix2_64p_out_framer

Output framer sitting directly downstream of the 64-point DIF radix-2 FFT top. It takes the FFT's free-running output stream (no backpressure available upstream), tags each sample with its bin index and frame boundaries, optionally computes magnitude-squared, and buffers the result in a first-word-fall-through FIFO. The FIFO drains through a valid/ready interface. Samples that arrive while the FIFO is full are dropped and counted.

## Interface
Parameters:
- DATA_WIDTH, 17, width of signed two's-complement re/im from the FFT.
- FIFO_DEPTH, 16, output FIFO entries; power of two, at least 4.
- FFT_NUM, 6, log2 of points per frame; the bin index is FFT_NUM bits.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- din_re  in  DATA_WIDTH  FFT output real part, signed.
- din_im  in  DATA_WIDTH  FFT output imag part, signed.
- din_valid  in  1  FFT output valid; there is no ready back to the FFT.
- dout_valid  out  1  FIFO head is valid.
- dout_ready  in  1  consumer accepts the head when high together with dout_valid.
- dout_re  out  DATA_WIDTH  head real part.
- dout_im  out  DATA_WIDTH  head imag part.
- dout_mag  out  2*DATA_WIDTH  head re²+im², unsigned.
- dout_bin  out  FFT_NUM  head bin index, 0..2^FFT_NUM-1.
- dout_sop  out  1  head is bin 0.
- dout_eop  out  1  head is bin 2^FFT_NUM-1.
- ovf  out  1  sticky: at least one sample has been dropped.
- drop_cnt  out  8  saturating count of dropped samples.
- ovf_clr  in  1  synchronous clear of ovf and drop_cnt.

## Operation
- Bin counter, FFT_NUM bits:
  - Increments on every din_valid sample and wraps from 2^FFT_NUM-1 to 0.
  - Counts input samples, not written entries, so tags stay correct when samples are dropped.
- Stage 1 (register): captures re, im, bin, sop = (bin==0) and eop = (bin==max) when din_valid; the stage valid bit follows din_valid.
- Stage 2 (register): computes mag = re*re + im*im as signed products summed into 2*DATA_WIDTH unsigned bits.
  - Worst case (-2^(W-1))² × 2 = 2^(2W-1), which fits, so there is no saturation.
  - re, im and the tags pass through unchanged.
- FIFO write: when stage-2 valid is high.
  - If the FIFO is full and no read happens this cycle, the sample is dropped: ovf is set and drop_cnt increments, saturating at 255.
  - If full and a read does happen in the same cycle, the write is accepted.
- FIFO read: when dout_valid && dout_ready. An empty FIFO ignores dout_ready.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits each.
  - Full when the MSBs differ and the remaining bits are equal.
  - Empty when the pointers are equal.
- ovf_clr:
  - Clears ovf and drop_cnt.
  - If a drop happens in the same cycle, the drop wins: ovf=1, drop_cnt=1.
- Reset values (async, rst high):
  - Bin counter, both stage valids and FIFO pointers are 0.
  - dout_valid, ovf and drop_cnt are 0.
  - Data outputs are 0.
- Reset asserted mid-frame discards all in-flight and buffered samples. The first sample after release is tagged bin 0.

## Timing
- Latency: a sample on din_valid at edge t is at the FIFO head, with dout_valid high, after edge t+2 when the FIFO was empty. It is consumable at edge t+3.
- Sustained throughput is one sample per cycle when dout_ready is held high; no bubbles are inserted.
- dout_* are registered FIFO outputs and stay stable while dout_valid && !dout_ready.
- ovf and drop_cnt update at the edge where the drop happens, i.e. the edge on which the stage-2 sample would have been written.

## Configuration
- FFT_OUT_MAG_EN defined: stage 2 includes the two multipliers and the adder, and dout_mag carries re²+im².
- FFT_OUT_MAG_EN undefined:
  - No multipliers; dout_mag is tied to 0 and no FIFO storage is allocated for it.
  - Stage 2 remains as a plain register, so latency is identical in both builds.

## Test plan
- Reset then 64 consecutive din_valid samples with re=k, im=-k (k=0..63), dout_ready=1:
  - Outputs appear 2 cycles later, bins 0..63.
  - sop only on bin 0, eop only on bin 63.
  - dout_mag = 2k².
- Extremes: re=im=-65536 (DATA_WIDTH=17) -> dout_mag = 2^33; re=65535, im=0 -> dout_mag = 4294836225.
- Hold dout_ready=0 with FIFO_DEPTH=16 and feed 20 samples:
  - 16 are stored; ovf goes high on the 17th; drop_cnt=4.
  - Draining then yields bins 0..15 in order.
  - The next frame's first sample is still tagged bin 0 after 64 total inputs.
- FIFO full, simultaneous read and write with dout_ready=1:
  - No drop; ovf stays 0.
  - The occupancy stays at 16.
- Drop and ovf_clr in the same cycle -> ovf=1, drop_cnt=1. 300 drops -> drop_cnt saturates at 255.
- rst pulse mid-frame after bin 30:
  - dout_valid drops immediately and the FIFO is empty.
  - The next input is tagged bin 0 with sop=1.
